mips_multicycle_control: RTL and testbench
==========================================

Name: mips_multicycle_control

Overview:
- Moore-style control FSM for the multicycle MIPS datapath. Successor to the single-cycle combinational decoder.
- Sequences each instruction through fetch / decode / execute / memory / writeback states.
- Adds the R-type ops sub, or and slt, plus lw, sw, beq and j.
- Inserts a parametrised number of memory wait cycles and flags illegal instructions.
- Sits between the instruction register (opcode/funct) and the datapath muxes, register file and memory strobes.

Parameters:
- MEM_WAIT, 0, extra cycles each memory state (FETCH, MEMRD, MEMWR) is held; legal range 0..15.
- ALU_OP_W, 3, width of alu_op; fixed encoding: and=000, or=001, add=010, sub=110, slt=111.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instruction[31:26] from IR; stable from DECODE onward
- funct  in  6  instruction[5:0] from IR
- alu_zero  in  1  ALU zero flag, used in BRANCH
- state  out  4  current state, for debug
- alu_op  out  ALU_OP_W  ALU operation
- alu_src_a  out  1  0=PC, 1=rs
- alu_src_b  out  2  00=rt, 01=const 4, 10=sign-extended imm, 11=imm<<2
- reg_dst  out  1  1=rd, 0=rt
- reg_write  out  1  register file write enable
- mem_to_reg  out  1  1=memory data, 0=ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- i_or_d  out  1  0=PC address, 1=ALUOut address
- ir_write  out  1  IR load enable
- pc_write  out  1  PC load enable
- pc_src  out  2  00=ALU result, 01=ALUOut (branch target), 10=jump target
- illegal  out  1  one-cycle pulse on an undecodable instruction

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, ADDIEX=10, ADDIWB=11, JUMP=12, TRAP=13.
- Registered state: the state register and a 4-bit wait counter.
- Output logic: all outputs are combinational from state (plus funct in EXEC, alu_zero in BRANCH).
- Default value of every output is 0 unless listed for the state below.

Reset:
- rst_n low: state=IDLE and counter=0 immediately (asynchronous). All outputs 0; state port reads 0.
- IDLE lasts exactly 1 cycle after rst_n deasserts, then the FSM goes to FETCH.
- Reset asserted in any state aborts the instruction. No strobe may stay asserted while rst_n is low.

Wait counter (applies in FETCH, MEMRD, MEMWR):
- Counter increments each cycle while counter != MEM_WAIT; the state holds during this time.
- The state exits on the cycle where counter == MEM_WAIT.
- Counter clears to 0 on exit.
- mem_read / mem_write are held high for all MEM_WAIT+1 cycles.

Per-state outputs and transitions:
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=010, pc_src=00. ir_write=1 and pc_write=1 only on the final cycle. -> DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=010. Next state by opcode:
  - 0x00 -> EXEC if funct is one of 0x20, 0x22, 0x24, 0x25, 0x2A; otherwise TRAP.
  - 0x23 or 0x2B -> MEMADR.
  - 0x04 -> BRANCH.
  - 0x08 -> ADDIEX.
  - 0x02 -> JUMP.
  - any other opcode -> TRAP.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=010. -> MEMRD if opcode=0x23, MEMWR if opcode=0x2B.
- MEMRD: mem_read=1, i_or_d=1. -> MEMWB after wait.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. -> FETCH.
- MEMWR: mem_write=1, i_or_d=1. -> FETCH after wait.
- EXEC: alu_src_a=1, alu_src_b=00. alu_op by funct: 0x20->010, 0x22->110, 0x24->000, 0x25->001, 0x2A->111. -> ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=110, pc_src=01, pc_write=alu_zero. -> FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=010. -> ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. -> FETCH.
- JUMP: pc_src=10, pc_write=1. -> FETCH.
- TRAP: illegal=1 for exactly one cycle; no write strobes. -> FETCH. The PC was already advanced in FETCH, so execution continues at PC+4.

Invariants:
- mem_read and mem_write are never both 1.
- reg_write and mem_write are never both 1.
- ir_write is 1 only in FETCH.

Test Plan:
- MEM_WAIT=0, rst_n released, IR=add (opcode 0x00, funct 0x20) -> states 0,1,2,7,8,1. alu_op=010 in EXEC. reg_write=1 with reg_dst=1 exactly in cycle 4 after IDLE. ir_write=pc_write=1 in cycle 1 only.
- MEM_WAIT=2, lw (0x23) -> FETCH lasts 3 cycles with mem_read held; ir_write only on the 3rd. MEMRD lasts 3 cycles with i_or_d=1. MEMWB reg_write=1, mem_to_reg=1. Total 9 cycles FETCH->FETCH.
- beq (0x04) with alu_zero=0, then repeat with alu_zero=1 -> pc_write=0 / 1 in BRANCH, pc_src=01, alu_op=110 both times.
- Illegal opcode 0x3F, then R-type funct 0x27 -> TRAP entered after DECODE. illegal=1 for exactly 1 cycle; no reg_write or mem_write; returns to FETCH.
- MEM_WAIT=3, sw (0x2B); assert rst_n low on 2nd MEMWR cycle -> mem_write drops to 0 immediately (asynchronous), state=0. After release: 1 IDLE cycle, then FETCH with counter=0 (4-cycle FETCH).
- Sweep sub/or/slt/addi/j -> alu_op 110/001/111 in EXEC. addi: alu_src_b=10, reg_dst=0. j: pc_src=10, pc_write=1. Check the invariants on every cycle.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives the datapath mux selects, register file and memory strobes.
//
// state  | meaning
// IDLE   | one cycle after reset release
// FETCH  | read instruction, PC+4 (IR/PC load on final wait cycle)
// DECODE | read registers, precompute branch target
// MEMADR | effective address for lw/sw
// MEMRD  | data memory read
// MEMWB  | load result to rt
// MEMWR  | data memory write
// EXEC   | R-type ALU operation
// ALUWB  | R-type result to rd
// BRANCH | beq compare, conditional PC load
// ADDIEX | addi ALU operation
// ADDIWB | addi result to rt
// JUMP   | PC load with jump target
// TRAP   | undecodable instruction, one-cycle illegal pulse
module mips_multicycle_control #(
  parameter int MEM_WAIT = 0,
  parameter int ALU_OP_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                alu_zero,
  output logic [3:0]          state,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                mem_read,
  output logic                mem_write,
  output logic                i_or_d,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                illegal
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,  FETCH  = 4'd1,  DECODE = 4'd2,  MEMADR = 4'd3,
    MEMRD  = 4'd4,  MEMWB  = 4'd5,  MEMWR  = 4'd6,  EXEC   = 4'd7,
    ALUWB  = 4'd8,  BRANCH = 4'd9,  ADDIEX = 4'd10, ADDIWB = 4'd11,
    JUMP   = 4'd12, TRAP   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(3'b000);
  localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(3'b001);
  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(3'b010);
  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(3'b110);
  localparam logic [ALU_OP_W-1:0] ALU_SLT = ALU_OP_W'(3'b111);

  localparam logic [3:0] WAIT_MAX = 4'(MEM_WAIT);

  state_t     state_q, state_d;
  logic [3:0] cnt_q;
  logic       mem_state;
  logic       wait_done;
  logic       funct_ok;

  assign state     = state_q;
  assign mem_state = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
  assign wait_done = (cnt_q == WAIT_MAX);
  assign funct_ok  = (funct == 6'h20) || (funct == 6'h22) || (funct == 6'h24) ||
                     (funct == 6'h25) || (funct == 6'h2A);

  // Counter only runs inside memory states and is zero on entry to each one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (mem_state && !wait_done) ? cnt_q + 4'd1 : 4'd0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   state_d = FETCH;
      FETCH:  if (wait_done) state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = funct_ok ? EXEC : TRAP;
          OP_LW, OP_SW: state_d = MEMADR;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = TRAP;
        endcase
      end
      MEMADR: state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  if (wait_done) state_d = MEMWB;
      MEMWR:  if (wait_done) state_d = FETCH;
      EXEC:   state_d = ALUWB;
      ADDIEX: state_d = ADDIWB;
      MEMWB, ALUWB, BRANCH, ADDIWB, JUMP, TRAP: state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alu_op     = '0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    illegal    = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = ALU_ADD;
        ir_write  = wait_done;
        pc_write  = wait_done;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = ALU_ADD;
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_ADD;
      end
      MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        case (funct)
          6'h22:   alu_op = ALU_SUB;
          6'h24:   alu_op = ALU_AND;
          6'h25:   alu_op = ALU_OR;
          6'h2A:   alu_op = ALU_SLT;
          default: alu_op = ALU_ADD;
        endcase
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = 2'b01;
        pc_write  = alu_zero;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_ADD;
      end
      ADDIWB:  reg_write = 1'b1;
      JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      TRAP:    illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: three instances with MEM_WAIT 0/2/3,
// cycle-by-cycle comparison of every output against hand-written state vectors.
module tb_mips_multicycle_control;

  localparam int NDUT = 3;

  logic       clk;
  logic       rst_n [NDUT];
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       alu_zero;

  logic [3:0] state      [NDUT];
  logic [2:0] alu_op     [NDUT];
  logic       alu_src_a  [NDUT];
  logic [1:0] alu_src_b  [NDUT];
  logic       reg_dst    [NDUT];
  logic       reg_write  [NDUT];
  logic       mem_to_reg [NDUT];
  logic       mem_read   [NDUT];
  logic       mem_write  [NDUT];
  logic       i_or_d     [NDUT];
  logic       ir_write   [NDUT];
  logic       pc_write   [NDUT];
  logic [1:0] pc_src     [NDUT];
  logic       illegal    [NDUT];

  int n_tests;
  int n_fail;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int WAIT_CYC = (g == 0) ? 0 : (g == 1) ? 2 : 3;
    mips_multicycle_control #(.MEM_WAIT(WAIT_CYC), .ALU_OP_W(3)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n[g]),
      .opcode     (opcode),
      .funct      (funct),
      .alu_zero   (alu_zero),
      .state      (state[g]),
      .alu_op     (alu_op[g]),
      .alu_src_a  (alu_src_a[g]),
      .alu_src_b  (alu_src_b[g]),
      .reg_dst    (reg_dst[g]),
      .reg_write  (reg_write[g]),
      .mem_to_reg (mem_to_reg[g]),
      .mem_read   (mem_read[g]),
      .mem_write  (mem_write[g]),
      .i_or_d     (i_or_d[g]),
      .ir_write   (ir_write[g]),
      .pc_write   (pc_write[g]),
      .pc_src     (pc_src[g]),
      .illegal    (illegal[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Field order: state, alu_op, src_a, src_b, reg_dst, reg_write, mem_to_reg,
  // mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src, illegal
  function automatic logic [20:0] ov(logic [3:0] st, logic [2:0] alu, logic sa, logic [1:0] sb,
                                     logic rd, logic rw, logic m2r, logic mr, logic mw,
                                     logic iod, logic irw, logic pcw, logic [1:0] pcs, logic ill);
    return {st, alu, sa, sb, rd, rw, m2r, mr, mw, iod, irw, pcw, pcs, ill};
  endfunction

  localparam logic [20:0] V_IDLE   = ov(4'd0,  3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
  localparam logic [20:0] V_FETCH  = ov(4'd1,  3'b010, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
  localparam logic [20:0] V_FETCHF = ov(4'd1,  3'b010, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0);
  localparam logic [20:0] V_DECODE = ov(4'd2,  3'b010, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
  localparam logic [20:0] V_MEMADR = ov(4'd3,  3'b010, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
  localparam logic [20:0] V_MEMRD  = ov(4'd4,  3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
  localparam logic [20:0] V_MEMWB  = ov(4'd5,  3'b000, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
  localparam logic [20:0] V_MEMWR  = ov(4'd6,  3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
  localparam logic [20:0] V_EX_ADD = ov(4'd7,  3'b010, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
  localparam logic [20:0] V_EX_SUB = ov(4'd7,  3'b110, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
  localparam logic [20:0] V_EX_AND = ov(4'd7,  3'b000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
  localparam logic [20:0] V_EX_OR  = ov(4'd7,  3'b001, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
  localparam logic [20:0] V_EX_SLT = ov(4'd7,  3'b111, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
  localparam logic [20:0] V_ALUWB  = ov(4'd8,  3'b000, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
  localparam logic [20:0] V_BR0    = ov(4'd9,  3'b110, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
  localparam logic [20:0] V_BR1    = ov(4'd9,  3'b110, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
  localparam logic [20:0] V_ADDIEX = ov(4'd10, 3'b010, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
  localparam logic [20:0] V_ADDIWB = ov(4'd11, 3'b000, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
  localparam logic [20:0] V_JUMP   = ov(4'd12, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0);
  localparam logic [20:0] V_TRAP   = ov(4'd13, 3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);

  logic [20:0] exp_q [$];

  task automatic chk(input string tag, input logic [20:0] got, input logic [20:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %06h expected %06h", tag, got, exp);
    end
  endtask

  function automatic logic [20:0] obs(input int d);
    return {state[d], alu_op[d], alu_src_a[d], alu_src_b[d], reg_dst[d], reg_write[d],
            mem_to_reg[d], mem_read[d], mem_write[d], i_or_d[d], ir_write[d], pc_write[d],
            pc_src[d], illegal[d]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // First queued vector is checked in the current cycle, each later one a cycle on.
  task automatic run_seq(input int d, input string tag);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) step();
      chk($sformatf("d%0d_%s[%0d]", d, tag, i), obs(d), exp_q[i]);
    end
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("d%0d_inv_rd_wr", d), 21'(mem_read[d] & mem_write[d]), 21'd0);
      chk($sformatf("d%0d_inv_rw_wr", d), 21'(reg_write[d] & mem_write[d]), 21'd0);
      chk($sformatf("d%0d_inv_irw", d), 21'(ir_write[d] && (state[d] != 4'd1)), 21'd0);
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int d = 0; d < NDUT; d++) rst_n[d] = 1'b0;
    opcode   = 6'h00;
    funct    = 6'h20;
    alu_zero = 1'b0;
    step();
    step();
    for (int d = 0; d < NDUT; d++) chk($sformatf("d%0d_reset", d), obs(d), V_IDLE);

    // MEM_WAIT=0: add, beq x2, traps, R-type/addi/j sweep
    rst_n[0] = 1'b1;
    exp_q.push_back(V_IDLE);  exp_q.push_back(V_FETCHF); exp_q.push_back(V_DECODE);
    exp_q.push_back(V_EX_ADD); exp_q.push_back(V_ALUWB); exp_q.push_back(V_FETCHF);
    run_seq(0, "add");

    opcode = 6'h04; alu_zero = 1'b0;
    exp_q.push_back(V_FETCHF); exp_q.push_back(V_DECODE); exp_q.push_back(V_BR0); exp_q.push_back(V_FETCHF);
    run_seq(0, "beq_nz");
    alu_zero = 1'b1;
    exp_q.push_back(V_FETCHF); exp_q.push_back(V_DECODE); exp_q.push_back(V_BR1); exp_q.push_back(V_FETCHF);
    run_seq(0, "beq_z");
    alu_zero = 1'b0;

    opcode = 6'h3F;
    exp_q.push_back(V_FETCHF); exp_q.push_back(V_DECODE); exp_q.push_back(V_TRAP); exp_q.push_back(V_FETCHF);
    run_seq(0, "trap_op3f");
    opcode = 6'h00; funct = 6'h27;
    exp_q.push_back(V_FETCHF); exp_q.push_back(V_DECODE); exp_q.push_back(V_TRAP); exp_q.push_back(V_FETCHF);
    run_seq(0, "trap_fn27");

    funct = 6'h22;
    exp_q.push_back(V_FETCHF); exp_q.push_back(V_DECODE); exp_q.push_back(V_EX_SUB);
    exp_q.push_back(V_ALUWB); exp_q.push_back(V_FETCHF);
    run_seq(0, "sub");
    funct = 6'h25;
    exp_q.push_back(V_FETCHF); exp_q.push_back(V_DECODE); exp_q.push_back(V_EX_OR);
    exp_q.push_back(V_ALUWB); exp_q.push_back(V_FETCHF);
    run_seq(0, "or");
    funct = 6'h2A;
    exp_q.push_back(V_FETCHF); exp_q.push_back(V_DECODE); exp_q.push_back(V_EX_SLT);
    exp_q.push_back(V_ALUWB); exp_q.push_back(V_FETCHF);
    run_seq(0, "slt");
    funct = 6'h24;
    exp_q.push_back(V_FETCHF); exp_q.push_back(V_DECODE); exp_q.push_back(V_EX_AND);
    exp_q.push_back(V_ALUWB); exp_q.push_back(V_FETCHF);
    run_seq(0, "and");
    opcode = 6'h08;
    exp_q.push_back(V_FETCHF); exp_q.push_back(V_DECODE); exp_q.push_back(V_ADDIEX);
    exp_q.push_back(V_ADDIWB); exp_q.push_back(V_FETCHF);
    run_seq(0, "addi");
    opcode = 6'h02;
    exp_q.push_back(V_FETCHF); exp_q.push_back(V_DECODE); exp_q.push_back(V_JUMP); exp_q.push_back(V_FETCHF);
    run_seq(0, "j");
    rst_n[0] = 1'b0;

    // MEM_WAIT=2: lw then sw, 3-cycle memory states
    opcode = 6'h23;
    rst_n[1] = 1'b1;
    exp_q.push_back(V_IDLE);
    exp_q.push_back(V_FETCH);  exp_q.push_back(V_FETCH);  exp_q.push_back(V_FETCHF);
    exp_q.push_back(V_DECODE); exp_q.push_back(V_MEMADR);
    exp_q.push_back(V_MEMRD);  exp_q.push_back(V_MEMRD);  exp_q.push_back(V_MEMRD);
    exp_q.push_back(V_MEMWB);  exp_q.push_back(V_FETCH);
    run_seq(1, "lw_w2");
    opcode = 6'h2B;
    exp_q.push_back(V_FETCH);  exp_q.push_back(V_FETCH);  exp_q.push_back(V_FETCHF);
    exp_q.push_back(V_DECODE); exp_q.push_back(V_MEMADR);
    exp_q.push_back(V_MEMWR);  exp_q.push_back(V_MEMWR);  exp_q.push_back(V_MEMWR);
    exp_q.push_back(V_FETCH);
    run_seq(1, "sw_w2");
    rst_n[1] = 1'b0;

    // MEM_WAIT=3: sw aborted by reset on the 2nd MEMWR cycle
    rst_n[2] = 1'b1;
    exp_q.push_back(V_IDLE);
    exp_q.push_back(V_FETCH);  exp_q.push_back(V_FETCH);  exp_q.push_back(V_FETCH); exp_q.push_back(V_FETCHF);
    exp_q.push_back(V_DECODE); exp_q.push_back(V_MEMADR);
    exp_q.push_back(V_MEMWR);  exp_q.push_back(V_MEMWR);
    run_seq(2, "sw_w3");
    rst_n[2] = 1'b0;
    #1;
    chk("d2_async_rst", obs(2), V_IDLE);
    step();
    chk("d2_rst_hold", obs(2), V_IDLE);
    rst_n[2] = 1'b1;
    exp_q.push_back(V_IDLE);
    exp_q.push_back(V_FETCH);  exp_q.push_back(V_FETCH);  exp_q.push_back(V_FETCH); exp_q.push_back(V_FETCHF);
    exp_q.push_back(V_DECODE); exp_q.push_back(V_MEMADR);
    exp_q.push_back(V_MEMWR);  exp_q.push_back(V_MEMWR);  exp_q.push_back(V_MEMWR); exp_q.push_back(V_MEMWR);
    exp_q.push_back(V_FETCH);
    run_seq(2, "sw_w3_after_rst");

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
